memory_controller: RTL

- Sits directly downstream of the CPU's single memory port.
- Decodes each CPU address and routes it to an external synchronous block RAM or to an on-block memory-mapped IO page: switches, LEDs, a timer and a status register.
- Returns read data with a uniform one-cycle latency, so the multicycle controller sees one timing for every source.

---
 rtl/memory_controller.sv | 127 ++++++++++++
 1 files changed

// File: rtl/memory_controller.sv
// CPU memory-port decoder: routes to external block RAM or an on-block IO page
// (switches, LEDs, optional timer/status built with MEMCTL_TIMER_EN) with uniform 1-cycle read latency.
module memory_controller #(
    parameter int          RAM_ADDR_WIDTH = 14,
    parameter logic [15:0] IO_BASE        = 16'hFF00,
    parameter int          SWITCH_WIDTH   = 10,
    parameter int          PRESCALE       = 50000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cpu_write_enable,
    input  logic [15:0]               cpu_address,
    input  logic [15:0]               cpu_write_data,
    output logic [15:0]               cpu_read_data,
    output logic                      ram_write_enable,
    output logic [RAM_ADDR_WIDTH-1:0] ram_address,
    output logic [15:0]               ram_write_data,
    input  logic [15:0]               ram_read_data,
    input  logic [SWITCH_WIDTH-1:0]   switches,
    output logic [SWITCH_WIDTH-1:0]   leds
);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("PRESCALE must be >= 1");
    end

    logic                    is_io;
    logic                    io_wr;
    logic [7:0]              io_offset;
    logic [SWITCH_WIDTH-1:0] sync1_q, sync2_q;
    logic [SWITCH_WIDTH-1:0] leds_q, leds_d;
    logic                    sel_io_q, sel_io_d;
    logic [15:0]             io_data_q, io_data_d;

    always_comb begin
        is_io     = (cpu_address >= IO_BASE);
        io_offset = cpu_address[7:0];
        io_wr     = cpu_write_enable & is_io;
        sel_io_d  = is_io;
    end

    // RAM path is purely combinational; the strobe is held off while reset is low
    assign ram_address      = cpu_address[RAM_ADDR_WIDTH-1:0];
    assign ram_write_data   = cpu_write_data;
    assign ram_write_enable = cpu_write_enable & ~is_io & reset;

`ifdef MEMCTL_TIMER_EN
    localparam logic [31:0] PRESC_MAX = 32'(PRESCALE - 1);

    logic [31:0] presc_q, presc_d;
    logic [15:0] count_q, count_d, count_inc;
    logic [15:0] compare_q, compare_d;
    logic        flag_q, flag_d;
    logic        tick, count_wr;

    always_comb begin
        count_wr  = io_wr && (io_offset == 8'h02);
        tick      = (presc_q == PRESC_MAX);
        count_inc = count_q + 16'd1;
        presc_d   = tick ? 32'd0 : presc_q + 32'd1;
        count_d   = tick ? count_inc : count_q;
        compare_d = (io_wr && (io_offset == 8'h03)) ? cpu_write_data : compare_q;
        flag_d    = flag_q;
        if (io_wr && (io_offset == 8'h04) && cpu_write_data[0]) begin
            flag_d = 1'b0;
        end
        // A match compares against the compare value held before this edge; set beats clear
        if (tick && !count_wr && (count_inc == compare_q)) begin
            flag_d = 1'b1;
        end
        if (count_wr) begin
            count_d = 16'd0;
            presc_d = 32'd0;
        end
    end
`endif

    always_comb begin
        leds_d = leds_q;
        if (io_wr && (io_offset == 8'h01)) begin
            leds_d = cpu_write_data[SWITCH_WIDTH-1:0];
        end
        io_data_d = 16'd0;
        case (io_offset)
            8'h00: io_data_d[SWITCH_WIDTH-1:0] = sync2_q;
            8'h01: io_data_d[SWITCH_WIDTH-1:0] = leds_q;
`ifdef MEMCTL_TIMER_EN
            8'h02: io_data_d = count_q;
            8'h03: io_data_d = compare_q;
            8'h04: io_data_d[0] = flag_q;
`endif
            default: io_data_d = 16'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            leds_q    <= '0;
            sel_io_q  <= 1'b0;
            io_data_q <= 16'd0;
`ifdef MEMCTL_TIMER_EN
            presc_q   <= 32'd0;
            count_q   <= 16'd0;
            compare_q <= 16'hFFFF;
            flag_q    <= 1'b0;
`endif
        end else begin
            sync1_q   <= switches;
            sync2_q   <= sync1_q;
            leds_q    <= leds_d;
            sel_io_q  <= sel_io_d;
            io_data_q <= io_data_d;
`ifdef MEMCTL_TIMER_EN
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            flag_q    <= flag_d;
`endif
        end
    end

    assign leds          = leds_q;
    assign cpu_read_data = sel_io_q ? io_data_q : ram_read_data;

endmodule
